matrix_streamer: RTL and testbench
==================================

MATRIX_STREAMER -- requirements
Module: matrix_streamer

Interface
REQ-001 SHALL have parameter ELEM_W, default 8, element width in bits.
REQ-002 SHALL have parameter MAX_ROWS, default 32, maximum matrix rows.
REQ-003 SHALL have parameter MAX_COLS, default 32, maximum matrix columns.
REQ-004 SHALL have parameter SYM_W, default 2, output symbol width; ELEM_W mod SYM_W SHALL be 0 (elaboration error otherwise).
REQ-005 SHALL have port inter_refclk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port clear  in  1  synchronous abort to IDLE.
REQ-008 SHALL have port num_rows  in  $clog2(MAX_ROWS)+1  active rows, 1..MAX_ROWS, latched in IDLE.
REQ-009 SHALL have port num_cols  in  $clog2(MAX_COLS)+1  active columns, 1..MAX_COLS, latched in IDLE.
REQ-010 SHALL have port valid_data_in  in  1  write strobe.
REQ-011 SHALL have port row_addr  in  $clog2(MAX_ROWS)  write row.
REQ-012 SHALL have port col_addr  in  $clog2(MAX_COLS)  write column.
REQ-013 SHALL have port matrix_element  in  ELEM_W  write data.
REQ-014 SHALL have port data_request  in  1  start transmission.
REQ-015 SHALL have port out_ready  in  1  downstream accept.
REQ-016 SHALL have port sym_out  out  SYM_W  output symbol.
REQ-017 SHALL have port valid_data_out  out  1  sym_out valid.
REQ-018 SHALL have port compile_done  out  1  one-cycle pulse, matrix complete.
REQ-019 SHALL have port busy  out  1  high in any state except IDLE.
REQ-020 SHALL have port wr_err  out  1  sticky write-error flag.

Function
REQ-021 SHALL implement states IDLE, LOAD, READY, XMIT.
REQ-022 SHALL store elements in an internal MAX_ROWS*MAX_COLS x ELEM_W memory at address row*MAX_COLS+col, with a per-cell written bit and a fill counter.
REQ-023 IDLE: num_rows/num_cols latched every cycle; in-range valid_data_in writes the cell and moves to LOAD; dimensions then frozen until IDLE is re-entered.
REQ-024 In-range write = row_addr<num_rows and col_addr<num_cols (latched values); out-of-range writes ignored and set wr_err.
REQ-025 First write to a cell sets its bit and increments the counter; rewrite overwrites data, no increment, sets wr_err.
REQ-026 LOAD->READY on the cycle the counter reaches num_rows*num_cols; compile_done high exactly that next cycle (first READY cycle); 1x1 matrix goes IDLE->READY directly.
REQ-027 READY: valid_data_in ignored and sets wr_err; data_request sampled only in READY, moves to XMIT; data_request in LOAD ignored, even on the completing cycle.
REQ-028 XMIT: row-major over active region only, each element sent as ELEM_W/SYM_W symbols, MSB first.
REQ-029 First valid_data_out asserted exactly 2 cycles after data_request sampled high in READY.
REQ-030 Symbol transfers when valid_data_out and out_ready both high; sym_out and valid_data_out held stable while out_ready low.
REQ-031 With out_ready held high, no idle cycles between symbols or elements (read prefetch required).
REQ-032 After last symbol accepted: valid_data_out low next cycle, state IDLE, all written bits and counter cleared; wr_err kept.
REQ-033 clear high: next state IDLE, valid_data_out low, written bits, counter and wr_err cleared; memory contents not cleared; clear wins over every simultaneous event.
REQ-034 Full-size index arithmetic SHALL not overflow: address width $clog2(MAX_ROWS*MAX_COLS), counter width $clog2(MAX_ROWS*MAX_COLS)+1.

Reset
REQ-035 rst high: immediately IDLE; valid_data_out, compile_done, busy, wr_err = 0; sym_out = 0; written bits and counter 0; memory contents undefined.
REQ-036 rst mid-XMIT SHALL drop valid_data_out asynchronously; no further symbols until a new load completes.

Verification
REQ-037 2x2, writes (1,1)=0x00,(0,0)=0xA5,(1,0)=0xFF,(0,1)=0x3C, request, out_ready=1 -> compile_done once; 16 symbols 2,2,1,1,0,3,3,0,3,3,3,3,0,0,0,0 back-to-back, first 2 cycles after request.
REQ-038 Same load, out_ready toggling 1,0,0,1 repeating -> identical sequence; sym_out stable during stall cycles; no symbol lost or duplicated.
REQ-039 3x2 load with (0,0) written twice (0x11 then 0x22) -> wr_err=1; compile_done only after 6 distinct cells; first element sent 0x22.
REQ-040 num_rows=2, num_cols=2, write (2,0) and (0,3) -> both ignored, wr_err=1, counter unchanged, state unchanged.
REQ-041 rst asserted after 5 symbols of a 2x2 transfer -> valid_data_out 0 immediately, busy 0; fresh 1x1 load of 0xC3 then request -> 3,0,0,3.
REQ-042 32x32 full load, random order, request -> 4096 symbols, last element from address 1023, then IDLE with busy=0.

Source files
------------

// File: rtl/matrix_streamer.sv
// matrix_streamer
//   Collects a matrix of up to MAX_ROWS x MAX_COLS elements, written in any
//   order. Once every active cell has been written, the matrix is streamed out
//   on request. The stream is row-major, and each element is sent as
//   ELEM_W/SYM_W symbols, most significant symbol first.
//
// Ports
//   inter_refclk    sole clock, rising edge
//   rst             asynchronous active-high reset
//   clear           synchronous abort to IDLE (clears fill tracking and wr_err)
//   num_rows/cols   active dimensions, sampled while IDLE
//   valid_data_in   write strobe for row_addr/col_addr/matrix_element
//   data_request    start streaming (honoured only in READY)
//   out_ready       downstream accept
//   sym_out         output symbol
//   valid_data_out  sym_out valid
//   compile_done    one-cycle pulse on the first READY cycle
//   busy            state is not IDLE
//   wr_err          sticky: out-of-range, rewritten-cell or READY-state write
//   dbg_state       current FSM state (IDLE=0, LOAD=1, READY=2, XMIT=3)
//
// Output handshake: a symbol moves when valid_data_out and out_ready are both
// high on a rising edge. While valid_data_out is high and out_ready is low,
// sym_out and valid_data_out hold. Only rst or clear can withdraw a presented
// symbol.
module matrix_streamer #(
  parameter int ELEM_W   = 8,
  parameter int MAX_ROWS = 32,
  parameter int MAX_COLS = 32,
  parameter int SYM_W    = 2
) (
  input  logic                        inter_refclk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic [$clog2(MAX_ROWS):0]   num_rows,
  input  logic [$clog2(MAX_COLS):0]   num_cols,
  input  logic                        valid_data_in,
  input  logic [$clog2(MAX_ROWS)-1:0] row_addr,
  input  logic [$clog2(MAX_COLS)-1:0] col_addr,
  input  logic [ELEM_W-1:0]           matrix_element,
  input  logic                        data_request,
  input  logic                        out_ready,
  output logic [SYM_W-1:0]            sym_out,
  output logic                        valid_data_out,
  output logic                        compile_done,
  output logic                        busy,
  output logic                        wr_err,
  output logic [1:0]                  dbg_state
);
  localparam int RW    = $clog2(MAX_ROWS);
  localparam int CW    = $clog2(MAX_COLS);
  localparam int DEPTH = MAX_ROWS * MAX_COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam int NW    = AW + 1;
  localparam int NSYM  = ELEM_W / SYM_W;
  localparam int SW    = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [AW-1:0] COLS_A = AW'(MAX_COLS);

  if (ELEM_W % SYM_W != 0) begin : g_bad_sym_w
    $error("matrix_streamer: ELEM_W must be a multiple of SYM_W");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2,
    S_XMIT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [RW:0]        rows_q, rows_d;
  logic [CW:0]        cols_q, cols_d;
  logic [DEPTH-1:0]   written_q, written_d;
  logic [NW-1:0]      fill_q, fill_d;
  logic               wr_err_q, wr_err_d;
  logic               done_q, done_d;
  logic [RW-1:0]      rd_r_q, rd_r_d;
  logic [CW-1:0]      rd_c_q, rd_c_d;
  logic [NW-1:0]      rd_rem_q, rd_rem_d;
  logic               pf_vld_q, pf_vld_d;
  logic [ELEM_W-1:0]  pf_q;
  logic [ELEM_W-1:0]  out_q, out_d;
  logic               out_vld_q, out_vld_d;
  logic [SW-1:0]      sym_cnt_q, sym_cnt_d;

  logic [ELEM_W-1:0]  mem [DEPTH];
  logic               mem_we;

  logic [AW-1:0]      wr_addr, rd_addr;
  logic [NW-1:0]      total, fill_inc;
  logic               wr_in_range, accept, last_sym, load_out, pf_fill;

  assign wr_in_range = ({1'b0, row_addr} < rows_q) && ({1'b0, col_addr} < cols_q);
  assign wr_addr     = AW'(row_addr) * COLS_A + AW'(col_addr);
  assign rd_addr     = AW'(rd_r_q) * COLS_A + AW'(rd_c_q);
  assign total       = NW'(rows_q) * NW'(cols_q);
  assign fill_inc    = fill_q + NW'(1);

  assign accept   = out_vld_q && out_ready;
  assign last_sym = (sym_cnt_q == SW'(NSYM - 1));
  // The output register takes the prefetched element when it is empty, or as
  // its final symbol leaves. This keeps the stream gap-free.
  assign load_out = pf_vld_q && (!out_vld_q || (accept && last_sym));
  // The prefetch register refills whenever it is empty or being drained.
  assign pf_fill  = (state_q == S_XMIT) && (rd_rem_q != '0) && (!pf_vld_q || load_out);

  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    written_d = written_q;
    fill_d    = fill_q;
    wr_err_d  = wr_err_q;
    done_d    = 1'b0;
    rd_r_d    = rd_r_q;
    rd_c_d    = rd_c_q;
    rd_rem_d  = rd_rem_q;
    pf_vld_d  = pf_vld_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    sym_cnt_d = sym_cnt_q;
    mem_we    = 1'b0;

    case (state_q)
      S_IDLE, S_LOAD: begin
        // Dimensions track the inputs only while IDLE. They freeze on the
        // cycle of the first accepted write.
        if (state_q == S_IDLE && !(valid_data_in && wr_in_range)) begin
          rows_d = num_rows;
          cols_d = num_cols;
        end
        if (valid_data_in) begin
          if (!wr_in_range) begin
            wr_err_d = 1'b1;
          end else begin
            mem_we = 1'b1;
            if (written_q[wr_addr]) begin
              wr_err_d = 1'b1;
            end else begin
              written_d[wr_addr] = 1'b1;
              fill_d             = fill_inc;
              if (fill_inc == total) begin
                state_d = S_READY;
                done_d  = 1'b1;
              end else begin
                state_d = S_LOAD;
              end
            end
          end
        end
      end
      S_READY: begin
        if (valid_data_in) wr_err_d = 1'b1;
        if (data_request) begin
          state_d  = S_XMIT;
          rd_r_d   = '0;
          rd_c_d   = '0;
          rd_rem_d = total;
        end
      end
      S_XMIT: begin
        if (pf_fill) begin
          rd_rem_d = rd_rem_q - NW'(1);
          if ({1'b0, rd_c_q} == cols_q - 1'b1) begin
            rd_c_d = '0;
            rd_r_d = rd_r_q + 1'b1;
          end else begin
            rd_c_d = rd_c_q + 1'b1;
          end
        end
        if (pf_fill)       pf_vld_d = 1'b1;
        else if (load_out) pf_vld_d = 1'b0;

        if (load_out) begin
          out_d     = pf_q;
          out_vld_d = 1'b1;
          sym_cnt_d = '0;
        end else if (accept) begin
          if (last_sym) begin
            out_vld_d = 1'b0;
          end else begin
            out_d     = out_q << SYM_W;
            sym_cnt_d = sym_cnt_q + 1'b1;
          end
        end

        // Final symbol of the final element accepted.
        if (accept && last_sym && !pf_vld_q && rd_rem_q == '0) begin
          state_d   = S_IDLE;
          written_d = '0;
          fill_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d   = S_IDLE;
      written_d = '0;
      fill_d    = '0;
      wr_err_d  = 1'b0;
      done_d    = 1'b0;
      pf_vld_d  = 1'b0;
      out_vld_d = 1'b0;
      mem_we    = 1'b0;
    end
  end

  always_ff @(posedge inter_refclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      written_q <= '0;
      fill_q    <= '0;
      wr_err_q  <= 1'b0;
      done_q    <= 1'b0;
      rd_r_q    <= '0;
      rd_c_q    <= '0;
      rd_rem_q  <= '0;
      pf_vld_q  <= 1'b0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      sym_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      written_q <= written_d;
      fill_q    <= fill_d;
      wr_err_q  <= wr_err_d;
      done_q    <= done_d;
      rd_r_q    <= rd_r_d;
      rd_c_q    <= rd_c_d;
      rd_rem_q  <= rd_rem_d;
      pf_vld_q  <= pf_vld_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      sym_cnt_q <= sym_cnt_d;
    end
  end

  // Element storage. It has no reset, and its contents survive clear.
  always_ff @(posedge inter_refclk) begin
    if (mem_we)  mem[wr_addr] <= matrix_element;
    if (pf_fill) pf_q <= mem[rd_addr];
  end

  assign sym_out        = out_q[ELEM_W-1 -: SYM_W];
  assign valid_data_out = out_vld_q;
  assign compile_done   = done_q;
  assign busy           = (state_q != S_IDLE);
  assign wr_err         = wr_err_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_matrix_streamer.sv
module tb_matrix_streamer;
  localparam int ELEM_W = 8;
  localparam int SYM_W  = 2;
  localparam int NSYM   = ELEM_W / SYM_W;
  localparam int MC     = 32;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_READY = 2'd2, ST_XMIT = 2'd3;

  // ---------------- clock / reset / DUT ----------------
  logic              inter_refclk = 1'b0;
  logic              rst, clear, valid_data_in, data_request, out_ready;
  logic [5:0]        num_rows, num_cols;
  logic [4:0]        row_addr, col_addr;
  logic [ELEM_W-1:0] matrix_element;
  logic [SYM_W-1:0]  sym_out;
  logic              valid_data_out, compile_done, busy, wr_err;
  logic [1:0]        dbg_state;

  always #5 inter_refclk = ~inter_refclk;

  matrix_streamer dut (
    .inter_refclk(inter_refclk), .rst(rst), .clear(clear),
    .num_rows(num_rows), .num_cols(num_cols),
    .valid_data_in(valid_data_in), .row_addr(row_addr), .col_addr(col_addr),
    .matrix_element(matrix_element), .data_request(data_request), .out_ready(out_ready),
    .sym_out(sym_out), .valid_data_out(valid_data_out), .compile_done(compile_done),
    .busy(busy), .wr_err(wr_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [SYM_W-1:0] exp_q[$];
  int rx_count, cd_count, cyc, first_acc, last_acc;
  logic [ELEM_W-1:0] last_word;
  bit stall_pending;
  logic [SYM_W-1:0] stall_sym;

  // Behavioural model of the matrix: contents, written cells, error flag.
  logic [ELEM_W-1:0] mdl [1024];
  bit   mwr [1024];
  int   mfill, cur_nr, cur_nc;
  bit   merr;

  logic [SYM_W-1:0] t1_syms [16] = '{2,2,1,1, 0,3,3,0, 3,3,3,3, 0,0,0,0};
  logic [SYM_W-1:0] c3_syms [4]  = '{3,0,0,3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(posedge inter_refclk) cyc++;

  // Output monitor: samples on the falling edge what the next rising edge will transfer.
  always @(negedge inter_refclk) begin
    if (rst) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending)
        check("stall_hold", {31'd0, valid_data_out} << SYM_W | 32'(sym_out), {31'd1, {SYM_W{1'b0}}} | 32'(stall_sym));
      stall_pending = valid_data_out && !out_ready && !clear;
      stall_sym     = sym_out;
      if (valid_data_out && out_ready) begin
        if (rx_count == 0) first_acc = cyc;
        last_acc  = cyc;
        rx_count++;
        last_word = {last_word[ELEM_W-SYM_W-1:0], sym_out};
        check("sym_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sym", 32'(sym_out), 32'(exp_q.pop_front()));
      end
      if (compile_done) cd_count++;
    end
  end

  // ---------------- model helpers ----------------
  task automatic mdl_new_load(input int nr, input int nc);
    for (int i = 0; i < 1024; i++) mwr[i] = 1'b0;
    mfill = 0; cur_nr = nr; cur_nc = nc;
  endtask

  task automatic mdl_write(input int r, input int c, input logic [ELEM_W-1:0] v);
    if (r < cur_nr && c < cur_nc) begin
      mdl[r*MC+c] = v;
      if (mwr[r*MC+c]) merr = 1'b1;
      else begin mwr[r*MC+c] = 1'b1; mfill++; end
    end else begin
      merr = 1'b1;
    end
  endtask

  task automatic push_matrix();
    logic [ELEM_W-1:0] t;
    for (int r = 0; r < cur_nr; r++)
      for (int c = 0; c < cur_nc; c++)
        for (int k = 0; k < NSYM; k++) begin
          t = mdl[r*MC+c] >> (ELEM_W - SYM_W*(k+1));
          exp_q.push_back(t[SYM_W-1:0]);
        end
  endtask

  // ---------------- driver tasks (all entered/exited at posedge+1) ----------------
  task automatic tick();
    @(posedge inter_refclk); #1;
  endtask

  task automatic set_dims(input int nr, input int nc);
    num_rows = 6'(nr); num_cols = 6'(nc);
    tick(); tick();
    mdl_new_load(nr, nc);
  endtask

  task automatic write_cell(input int r, input int c, input logic [ELEM_W-1:0] v);
    row_addr = 5'(r); col_addr = 5'(c); matrix_element = v; valid_data_in = 1'b1;
    tick();
    valid_data_in = 1'b0;
    mdl_write(r, c, v);
  endtask

  task automatic request();
    rx_count = 0;
    data_request = 1'b1;
    tick();
    data_request = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
    merr = 1'b0;
  endtask

  // mode 0: out_ready high, 1: pattern 1,0,0,1, 2: random
  task automatic wait_done(input int mode, input int limit, input string name);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < limit) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (n % 4 == 0) || (n % 4 == 3);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      tick();
      n++;
      if (!busy) done = 1'b1;
    end
    out_ready = 1'b1;
    check({name, "_done_in_budget"}, 32'(done), 32'd1);
  endtask

  task automatic load_2x2();
    set_dims(2, 2);
    write_cell(1, 1, 8'h00);
    write_cell(0, 0, 8'hA5);
    write_cell(1, 0, 8'hFF);
    write_cell(0, 1, 8'h3C);
  endtask

  // Random load: every active cell once in shuffled order, optionally with
  // out-of-range writes and rewrites mixed in before completion.
  task automatic load_random(input int nr, input int nc, input bit extras);
    int cells[$];
    int j, tmp, r, c, d;
    set_dims(nr, nc);
    for (int i = 0; i < nr*nc; i++) cells.push_back((i / nc) * MC + (i % nc));
    for (int i = nr*nc - 1; i > 0; i--) begin
      j = $urandom_range(0, i); tmp = cells[i]; cells[i] = cells[j]; cells[j] = tmp;
    end
    for (int i = 0; i < nr*nc; i++) begin
      if (extras && $urandom_range(0, 5) == 0) begin
        if (i > 0 && $urandom_range(0, 1) == 0) begin
          d = cells[$urandom_range(0, i-1)];
          write_cell(d / MC, d % MC, 8'($urandom));
        end else if (nr < 32) begin
          r = nr; c = $urandom_range(0, nc-1);
          write_cell(r, c, 8'($urandom));
        end
      end
      write_cell(cells[i] / MC, cells[i] % MC, 8'($urandom));
    end
  endtask

  typedef struct {
    int r; int c; logic [7:0] d;
    logic e_err; logic e_busy; logic e_cd;
  } wvec_t;

  // ---------------- main sequence ----------------
  initial begin
    wvec_t tbl [9];
    int nr, nc;
    tbl[0] = '{0, 0, 8'h11, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{0, 0, 8'h22, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{3, 0, 8'h99, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{0, 2, 8'h98, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{0, 1, 8'h33, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1, 0, 8'h44, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1, 1, 8'h55, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{2, 0, 8'h66, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{2, 1, 8'h77, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; clear = 1'b0; valid_data_in = 1'b0; data_request = 1'b0; out_ready = 1'b1;
    num_rows = 6'd1; num_cols = 6'd1; row_addr = '0; col_addr = '0; matrix_element = '0;
    rx_count = 0; cd_count = 0; merr = 1'b0; last_word = '0; first_acc = 0; last_acc = 0;
    tick(); tick();
    check("rst_valid", 32'(valid_data_out), 32'd0);
    check("rst_cd", 32'(compile_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_sym", 32'(sym_out), 32'd0);
    rst = 1'b0;
    tick();

    // 2x2 reference transfer, out_ready held high
    cd_count = 0;
    load_2x2();
    check("t1_state_ready", 32'(dbg_state), 32'(ST_READY));
    check("t1_cd_pulse", 32'(compile_done), 32'd1);
    for (int i = 0; i < 16; i++) exp_q.push_back(t1_syms[i]);
    request();
    check("t1_xmit", 32'(dbg_state), 32'(ST_XMIT));
    check("t1_lat0", 32'(valid_data_out), 32'd0);
    tick();
    check("t1_lat1", 32'(valid_data_out), 32'd0);
    tick();
    check("t1_lat2", 32'(valid_data_out), 32'd1);
    wait_done(0, 100, "t1");
    check("t1_count", 32'(rx_count), 32'd16);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t1_back_to_back", 32'(last_acc - first_acc), 32'd15);
    check("t1_valid_low", 32'(valid_data_out), 32'd0);
    check("t1_cd_once", 32'(cd_count), 32'd1);
    check("t1_wr_err", 32'(wr_err), 32'd0);

    // same load with out_ready toggling 1,0,0,1
    load_2x2();
    for (int i = 0; i < 16; i++) exp_q.push_back(t1_syms[i]);
    request();
    wait_done(1, 200, "t2");
    check("t2_count", 32'(rx_count), 32'd16);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3x2 table: rewrite of (0,0), out-of-range writes
    cd_count = 0;
    set_dims(3, 2);
    foreach (tbl[i]) begin
      write_cell(tbl[i].r, tbl[i].c, tbl[i].d);
      check($sformatf("tbl%0d_wr_err", i), 32'(wr_err), 32'(tbl[i].e_err));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("tbl%0d_cd", i), 32'(compile_done), 32'(tbl[i].e_cd));
    end
    push_matrix();
    check("t3_first_elem_model", 32'(mdl[0]), 32'h22);
    request();
    wait_done(2, 200, "t3");
    check("t3_count", 32'(rx_count), 32'd24);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t3_cd_once", 32'(cd_count), 32'd1);
    check("t3_wr_err_kept", 32'(wr_err), 32'd1);

    // out-of-range writes in IDLE and LOAD; request during LOAD ignored; clear
    do_clear();
    check("t4_clear_wr_err", 32'(wr_err), 32'd0);
    cd_count = 0;
    set_dims(2, 2);
    write_cell(2, 0, 8'h10);
    check("t4_oor_row_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("t4_oor_row_err", 32'(wr_err), 32'd1);
    write_cell(0, 3, 8'h20);
    check("t4_oor_col_idle", 32'(busy), 32'd0);
    write_cell(0, 0, 8'h01);
    check("t4_load", 32'(dbg_state), 32'(ST_LOAD));
    write_cell(2, 0, 8'h30);
    check("t4_oor_load", 32'(dbg_state), 32'(ST_LOAD));
    write_cell(0, 1, 8'h02);
    write_cell(1, 0, 8'h03);
    check("t4_not_yet_ready", 32'(dbg_state), 32'(ST_LOAD));
    data_request = 1'b1;
    write_cell(1, 1, 8'h04);
    data_request = 1'b0;
    check("t4_ready", 32'(dbg_state), 32'(ST_READY));
    check("t4_cd", 32'(compile_done), 32'd1);
    tick(); tick();
    check("t4_req_in_load_ignored", 32'(dbg_state), 32'(ST_READY));
    check("t4_no_valid", 32'(valid_data_out), 32'd0);
    out_ready = 1'b0;
    request();
    tick(); tick(); tick();
    check("t4_valid_stalled", 32'(valid_data_out), 32'd1);
    do_clear();
    check("t4_clear_valid", 32'(valid_data_out), 32'd0);
    check("t4_clear_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    check("t4_cd_once", 32'(cd_count), 32'd1);
    check("t4_no_symbols", 32'(rx_count), 32'd0);

    // reset after five symbols, then 1x1 load of 0xC3
    load_2x2();
    for (int i = 0; i < 16; i++) exp_q.push_back(t1_syms[i]);
    request();
    for (int n = 0; n < 50 && rx_count < 5; n++) tick();
    check("t5_five_syms", 32'(rx_count), 32'd5);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(valid_data_out), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    merr = 1'b0;
    exp_q.delete();
    tick(); tick();
    check("t5_no_valid_after_rst", 32'(valid_data_out), 32'd0);
    set_dims(1, 1);
    write_cell(0, 0, 8'hC3);
    check("t5_1x1_ready", 32'(dbg_state), 32'(ST_READY));
    check("t5_1x1_cd", 32'(compile_done), 32'd1);
    write_cell(0, 0, 8'h5A);
    check("t5_ready_write_err", 32'(wr_err), 32'd1);
    check("t5_ready_write_state", 32'(dbg_state), 32'(ST_READY));
    for (int i = 0; i < 4; i++) exp_q.push_back(c3_syms[i]);
    request();
    wait_done(0, 50, "t5");
    check("t5_count", 32'(rx_count), 32'd4);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // randomized loads against the model
    do_clear();
    for (int k = 0; k < 4; k++) begin
      nr = $urandom_range(1, 6); nc = $urandom_range(1, 6);
      cd_count = 0;
      load_random(nr, nc, 1'b1);
      check($sformatf("r%0d_ready", k), 32'(dbg_state), 32'(ST_READY));
      check($sformatf("r%0d_wr_err", k), 32'(wr_err), 32'(merr));
      check($sformatf("r%0d_fill", k), 32'(mfill), 32'(nr*nc));
      push_matrix();
      request();
      wait_done(2, 2000, $sformatf("r%0d", k));
      check($sformatf("r%0d_count", k), 32'(rx_count), 32'(nr*nc*NSYM));
      check($sformatf("r%0d_queue_empty", k), 32'(exp_q.size()), 32'd0);
      check($sformatf("r%0d_cd_once", k), 32'(cd_count), 32'd1);
    end

    // full 32x32 load in random order
    do_clear();
    cd_count = 0;
    load_random(32, 32, 1'b0);
    check("full_ready", 32'(dbg_state), 32'(ST_READY));
    push_matrix();
    request();
    wait_done(2, 20000, "full");
    check("full_count", 32'(rx_count), 32'd4096);
    check("full_queue_empty", 32'(exp_q.size()), 32'd0);
    check("full_last_elem", 32'(last_word), 32'(mdl[1023]));
    check("full_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("full_busy", 32'(busy), 32'd0);
    check("full_cd_once", 32'(cd_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end
endmodule
